// File: rtl/bouncing_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : bouncing_sprite_engine
// Brief    : N-sprite bouncing-square renderer; positions step once per frame
//            via a sequential per-sprite update FSM, with wall-bounce events.
// Revision : 1.0 - initial release
// ============================================================================
module bouncing_sprite_engine #(
    parameter int N_SPRITES = 4,
    parameter int SIZE      = 64,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int DX_BASE   = 2,
    parameter int DY_BASE   = 3,
    parameter logic [6*N_SPRITES-1:0] PALETTE =
        {6'b111100, 6'b000011, 6'b001100, 6'b110000}
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       video_active,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pause,
    input  logic       speed_x2,
    output logic [5:0] rgb,
    output logic       bounce_pulse,
    output logic [7:0] bounce_count,
    output logic       busy
);

    localparam int                 C_IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam logic [9:0]         C_XL    = 10'(H_RES - SIZE);
    localparam logic [9:0]         C_YL    = 10'(V_RES - SIZE);
    localparam logic [10:0]        C_SIZE  = 11'(SIZE);
    localparam logic [C_IDX_W-1:0] C_LAST  = C_IDX_W'(N_SPRITES - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_t;

    state_t               r_state;
    logic [C_IDX_W-1:0]   r_idx;
    logic                 r_vsync_q;
    logic                 r_x2;
    logic [9:0]           r_x [N_SPRITES];
    logic [9:0]           r_y [N_SPRITES];
    logic [N_SPRITES-1:0] r_xdir;
    logic [N_SPRITES-1:0] r_ydir;

    logic        w_tick;
    logic [9:0]  w_bx, w_by, w_sx, w_sy;
    logic [11:0] w_xs, w_ys;
    logic [1:0]  w_nb;

    // Result packing: {bounce, new_dir, new_pos}. The sum is formed in 11 bits
    // and the decrement path never goes below zero.
    function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] spd, input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, spd};
        if (dir) begin
            if (sum >= {1'b0, lim}) return {1'b1, 1'b0, lim};
            else                    return {1'b0, 1'b1, sum[9:0]};
        end else begin
            if (pos <= spd) return {1'b1, 1'b1, 10'd0};
            else            return {1'b0, 1'b0, pos - spd};
        end
    endfunction

    assign w_tick = vsync & ~r_vsync_q & ~pause & (r_state == S_IDLE);
    assign busy   = (r_state == S_UPDATE);

    always_comb begin
        w_bx = 10'(DX_BASE) + 10'(r_idx);
        w_by = 10'(DY_BASE) + 10'(r_idx);
        w_sx = r_x2 ? {w_bx[8:0], 1'b0} : w_bx;
        w_sy = r_x2 ? {w_by[8:0], 1'b0} : w_by;
        w_xs = axis_step(r_x[r_idx], r_xdir[r_idx], w_sx, C_XL);
        w_ys = axis_step(r_y[r_idx], r_ydir[r_idx], w_sy, C_YL);
        w_nb = {1'b0, w_xs[11]} + {1'b0, w_ys[11]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_vsync_q    <= 1'b0;
            r_x2         <= 1'b0;
            bounce_pulse <= 1'b0;
            bounce_count <= 8'd0;
            for (int i = 0; i < N_SPRITES; i++) begin
                r_x[i]    <= 10'(i * (H_RES / N_SPRITES));
                r_y[i]    <= 10'(i * 64);
                r_xdir[i] <= (i % 2 == 0);
                r_ydir[i] <= 1'b1;
            end
        end else begin
            r_vsync_q    <= vsync;
            bounce_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state <= S_UPDATE;
                        r_idx   <= '0;
                        r_x2    <= speed_x2;
                    end
                end
                S_UPDATE: begin
                    r_x[r_idx]    <= w_xs[9:0];
                    r_xdir[r_idx] <= w_xs[10];
                    r_y[r_idx]    <= w_ys[9:0];
                    r_ydir[r_idx] <= w_ys[10];
                    bounce_pulse  <= |w_nb;
                    bounce_count  <= bounce_count + {6'd0, w_nb};
                    if (r_idx == C_LAST) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + C_IDX_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [N_SPRITES-1:0] w_hit;
    logic [5:0]           w_color;

    generate
        for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
            assign w_hit[g] = ({1'b0, pix_x} >= {1'b0, r_x[g]}) &&
                              ({1'b0, pix_x} <  ({1'b0, r_x[g]} + C_SIZE)) &&
                              ({1'b0, pix_y} >= {1'b0, r_y[g]}) &&
                              ({1'b0, pix_y} <  ({1'b0, r_y[g]} + C_SIZE));
        end
    endgenerate

    // Walk from the top index down so the lowest-index hit has the last word.
    always_comb begin
        w_color = 6'd0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) w_color = PALETTE[6*i +: 6];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= 6'd0;
        else        rgb <= video_active ? w_color : 6'd0;
    end

endmodule
`default_nettype wire
